id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage for the 5-stage MIPS core. Sits between IF/ID and EX, directly in front of regfile.
//  Each cycle: decodes inst; drives regfile read ports; forwards operands from EX/MEM results.
//  Detects load-use hazards and registers the decoded op into the ID/EX pipeline register.
// PARAMETERS
//  DATA_W  32  operand / instruction width
//  ADDR_W  5   register address width (32 registers)
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   synchronous reset, active-high
//  id_valid     in   1   IF/ID holds a real instruction
//  id_pc        in   32  PC of id_inst
//  id_inst      in   32  instruction word
//  re1/re2      out  1   regfile read enables (combinational)
//  raddr1/2     out  5   regfile read addresses = rs/rt (combinational)
//  rdata1/2     in   32  regfile read data
//  ex_we        in   1   EX-stage result writes a register
//  ex_waddr     in   5   EX-stage destination
//  ex_wdata     in   32  EX-stage result
//  ex_is_load   in   1   EX-stage op is LW (data not yet available)
//  mem_we/mem_waddr/mem_wdata  in  1/5/32  MEM-stage write-back info
//  stall_in     in   1   downstream stall: hold ID/EX
//  flush        in   1   discard ID/EX contents (insert bubble)
//  stall_req    out  1   combinational: IF/ID must hold this cycle
//  ex_valid_o   out  1   ID/EX: valid op
//  ex_aluop_o   out  4   ID/EX: 0 NOP,1 OR,2 AND,3 XOR,4 NOR,5 ADD,6 SUB,7 SLT,8 SLL,9 SRL,10 SRA,11 LUI,12 LW
//  ex_reg1_o    out  32  ID/EX: operand 1
//  ex_reg2_o    out  32  ID/EX: operand 2
//  ex_wd_o      out  5   ID/EX: destination register
//  ex_wreg_o    out  1   ID/EX: destination write enable
//  ex_pc_o      out  32  ID/EX: PC
//  inst_invalid out  1   ID/EX: unsupported opcode seen (registered, with op)
// BEHAVIOUR
//  - Reset: all ID/EX outputs 0 (aluop=NOP, wreg=0, valid=0, inst_invalid=0).
//  - Decode: ORI/ANDI/XORI zero-extend imm; ADDIU/LW sign-extend imm; LUI reg2={imm,16'h0}.
//  - Decode: SPECIAL AND/OR/XOR/NOR/ADDU/SUBU/SLT use rd as dest; I-type uses rt.
//  - Shifts SLL/SRL/SRA: reg1={27'b0,sa}, reg2=rt value, re1=0.
//  - Unknown opcode: aluop=NOP, wreg=0, inst_invalid=1. id_valid=0: re1=re2=0; NOP bubble.
//  - Operand select, per port, priority high->low:
//    re=0 -> immediate/0; addr==0 -> 0; EX match (ex_we) -> ex_wdata; MEM match (mem_we) -> mem_wdata; else rdata.
//    regfile covers the WB-stage bypass.
//  - Load-use: stall_req=1 iff id_valid & ex_is_load & ex_we & ex_waddr!=0 & (re1&rs==ex_waddr | re2&rt==ex_waddr).
//  - ID/EX update, priority: rst > flush (bubble) > stall_in (hold all) > stall_req (bubble) > load decoded op.
//  - Latency: 1 cycle from IF/ID to ID/EX. Throughput: 1 op/cycle absent stalls.
//  - stall_req is still driven while stall_in=1; flush and stall_req in the same cycle -> bubble.
//  - Reset mid-stall clears ID/EX; stall_req then depends only on the current inputs.
//  - Writes to $0 are never forwarded: an addr==0 operand always reads 0.
// CONFIGURATION
//  ID_FORWARD_EN defined: EX/MEM forwarding as above.
//  ID_FORWARD_EN undefined: no EX/MEM forwarding; operands come from rdata only.
//    stall_req also asserts for any read matching a nonzero ex_waddr (ex_we) or mem_waddr (mem_we).
//    Loads and non-loads are treated alike.
// TESTING
//  1. rst=1 for 2 cycles with an ORI on inst -> all ID/EX outputs 0; after release, ORI issues 1 cycle later.
//  2. ORI $1,$0,0x1234 -> ex_aluop_o=1, reg1=0, reg2=0x00001234, wd=1, wreg=1.
//     LUI $2,0xABCD -> reg2=0xABCD0000.
//  3. FWD_EN: ADDU $3,$1,$2 with ex_waddr=1 (ex_wdata=5), mem_waddr=2 (mem_wdata=7) -> reg1=5, reg2=7.
//     Both EX and MEM targeting $1 -> EX value.
//  4. ex_is_load & ex_waddr=4, inst OR $5,$4,$6 -> stall_req=1; next ID/EX = bubble. ex_waddr=0 -> no stall.
//  5. stall_in=1 for 3 cycles -> ID/EX unchanged; flush=1 together with stall_in -> bubble.
//  6. No FWD_EN: mem_we & mem_waddr=6 with OR reading $6 -> stall_req=1. Opcode 6'h3F -> inst_invalid=1, wreg=0.

Source files
------------

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS ID stage: decode, operand bypass, load-use detect, ID/EX register
// Optional: `define ID_FORWARD_EN for EX/MEM forwarding; otherwise any pending EX/MEM write stalls.
module id_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_inst,
  output logic              re1,
  output logic              re2,
  output logic [ADDR_W-1:0] raddr1,
  output logic [ADDR_W-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              stall_in,
  input  logic              flush,
  output logic              stall_req,
  output logic              ex_valid_o,
  output logic [3:0]        ex_aluop_o,
  output logic [DATA_W-1:0] ex_reg1_o,
  output logic [DATA_W-1:0] ex_reg2_o,
  output logic [ADDR_W-1:0] ex_wd_o,
  output logic              ex_wreg_o,
  output logic [DATA_W-1:0] ex_pc_o,
  output logic              inst_invalid
);

  localparam logic [3:0] ALU_NOP = 4'd0,  ALU_OR  = 4'd1,  ALU_AND = 4'd2,  ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4,  ALU_ADD = 4'd5,  ALU_SUB = 4'd6,  ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8,  ALU_SRL = 4'd9,  ALU_SRA = 4'd10, ALU_LUI = 4'd11;
  localparam logic [3:0] ALU_LW  = 4'd12;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E, OP_LUI   = 6'h0F, OP_LW   = 6'h23;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR   = 6'h25, FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27, FN_SLT  = 6'h2A;

  logic [5:0]        opcode, funct;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [4:0]        sa;
  logic [15:0]       imm;

  assign opcode = id_inst[31:26];
  assign rs     = id_inst[21 +: ADDR_W];
  assign rt     = id_inst[16 +: ADDR_W];
  assign rd     = id_inst[11 +: ADDR_W];
  assign sa     = id_inst[10:6];
  assign funct  = id_inst[5:0];
  assign imm    = id_inst[15:0];

  logic [3:0]        dec_aluop;
  logic              dec_re1, dec_re2, dec_wreg, dec_bad;
  logic [ADDR_W-1:0] dec_wd;
  logic [DATA_W-1:0] imm1, imm2;

  always_comb begin
    dec_aluop = ALU_NOP;
    dec_re1   = 1'b0;
    dec_re2   = 1'b0;
    dec_wd    = '0;
    dec_wreg  = 1'b0;
    dec_bad   = 1'b0;
    imm1      = '0;
    imm2      = '0;
    case (opcode)
      OP_SPECIAL: begin
        dec_re1  = 1'b1;
        dec_re2  = 1'b1;
        dec_wd   = rd;
        dec_wreg = 1'b1;
        case (funct)
          FN_AND:  dec_aluop = ALU_AND;
          FN_OR:   dec_aluop = ALU_OR;
          FN_XOR:  dec_aluop = ALU_XOR;
          FN_NOR:  dec_aluop = ALU_NOR;
          FN_ADDU: dec_aluop = ALU_ADD;
          FN_SUBU: dec_aluop = ALU_SUB;
          FN_SLT:  dec_aluop = ALU_SLT;
          // Shifts take the shift amount as operand 1 instead of rs.
          FN_SLL: begin dec_aluop = ALU_SLL; dec_re1 = 1'b0; imm1 = DATA_W'(sa); end
          FN_SRL: begin dec_aluop = ALU_SRL; dec_re1 = 1'b0; imm1 = DATA_W'(sa); end
          FN_SRA: begin dec_aluop = ALU_SRA; dec_re1 = 1'b0; imm1 = DATA_W'(sa); end
          default: begin
            dec_re1  = 1'b0;
            dec_re2  = 1'b0;
            dec_wd   = '0;
            dec_wreg = 1'b0;
            dec_bad  = 1'b1;
          end
        endcase
      end
      OP_ORI:   begin dec_aluop = ALU_OR;  dec_re1 = 1'b1; dec_wd = rt; dec_wreg = 1'b1; imm2 = DATA_W'(imm); end
      OP_ANDI:  begin dec_aluop = ALU_AND; dec_re1 = 1'b1; dec_wd = rt; dec_wreg = 1'b1; imm2 = DATA_W'(imm); end
      OP_XORI:  begin dec_aluop = ALU_XOR; dec_re1 = 1'b1; dec_wd = rt; dec_wreg = 1'b1; imm2 = DATA_W'(imm); end
      OP_ADDIU: begin
        dec_aluop = ALU_ADD; dec_re1 = 1'b1; dec_wd = rt; dec_wreg = 1'b1;
        imm2 = {{(DATA_W-16){imm[15]}}, imm};
      end
      OP_LW: begin
        dec_aluop = ALU_LW; dec_re1 = 1'b1; dec_wd = rt; dec_wreg = 1'b1;
        imm2 = {{(DATA_W-16){imm[15]}}, imm};
      end
      OP_LUI: begin dec_aluop = ALU_LUI; dec_wd = rt; dec_wreg = 1'b1; imm2 = {imm, {(DATA_W-16){1'b0}}}; end
      default: dec_bad = 1'b1;
    endcase
  end

  assign re1    = id_valid & dec_re1;
  assign re2    = id_valid & dec_re2;
  assign raddr1 = rs;
  assign raddr2 = rt;

  function automatic logic [DATA_W-1:0] pick_operand(
    input logic re, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] k,
    input logic [DATA_W-1:0] rf, input logic xwe, input logic [ADDR_W-1:0] xa,
    input logic [DATA_W-1:0] xd, input logic mwe, input logic [ADDR_W-1:0] ma,
    input logic [DATA_W-1:0] md, input logic fwd);
    if (!re)                        return k;
    else if (a == '0)               return '0;
    else if (fwd && xwe && xa == a) return xd;
    else if (fwd && mwe && ma == a) return md;
    else                            return rf;
  endfunction

  // A read port conflicts with a write still in flight that it cannot take a bypass from.
  function automatic logic port_hazard(
    input logic re, input logic [ADDR_W-1:0] a, input logic xwe, input logic [ADDR_W-1:0] xa,
    input logic xload, input logic mwe, input logic [ADDR_W-1:0] ma, input logic fwd);
    logic ex_hit, mem_hit;
    ex_hit  = re && xwe && xa != '0 && xa == a;
    mem_hit = re && mwe && ma != '0 && ma == a;
    if (fwd) return ex_hit && xload;
    else     return ex_hit || mem_hit;
  endfunction

`ifdef ID_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
  logic unused_fwd;
  assign unused_fwd = ^{ex_wdata, mem_wdata, ex_is_load};
`endif

  logic [DATA_W-1:0] opnd1, opnd2;
  logic              bubble;

  assign opnd1 = pick_operand(dec_re1, rs, imm1, rdata1, ex_we, ex_waddr, ex_wdata,
                              mem_we, mem_waddr, mem_wdata, FWD);
  assign opnd2 = pick_operand(dec_re2, rt, imm2, rdata2, ex_we, ex_waddr, ex_wdata,
                              mem_we, mem_waddr, mem_wdata, FWD);

  assign stall_req = id_valid &
                     (port_hazard(dec_re1, rs, ex_we, ex_waddr, ex_is_load, mem_we, mem_waddr, FWD) |
                      port_hazard(dec_re2, rt, ex_we, ex_waddr, ex_is_load, mem_we, mem_waddr, FWD));

  assign bubble = flush | (~stall_in & (stall_req | ~id_valid));

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid_o   <= 1'b0;
      ex_aluop_o   <= ALU_NOP;
      ex_reg1_o    <= '0;
      ex_reg2_o    <= '0;
      ex_wd_o      <= '0;
      ex_wreg_o    <= 1'b0;
      ex_pc_o      <= '0;
      inst_invalid <= 1'b0;
    end else if (!stall_in) begin
      ex_valid_o   <= 1'b1;
      ex_aluop_o   <= dec_aluop;
      ex_reg1_o    <= opnd1;
      ex_reg2_o    <= opnd2;
      ex_wd_o      <= dec_wd;
      ex_wreg_o    <= dec_wreg;
      ex_pc_o      <= id_pc;
      inst_invalid <= dec_bad;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized self-checking bench for id_stage against a table-driven model
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, ex_we, ex_is_load, mem_we, stall_in, flush;
  logic [31:0] id_pc, id_inst, rdata1, rdata2, ex_wdata, mem_wdata;
  logic [4:0]  ex_waddr, mem_waddr;
  logic        re1, re2, stall_req, ex_valid_o, ex_wreg_o, inst_invalid;
  logic [4:0]  raddr1, raddr2, ex_wd_o;
  logic [3:0]  ex_aluop_o;
  logic [31:0] ex_reg1_o, ex_reg2_o, ex_pc_o;

  id_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .stall_in(stall_in), .flush(flush), .stall_req(stall_req),
    .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
    .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_pc_o(ex_pc_o), .inst_invalid(inst_invalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Mnemonic tables: SPECIAL functs and I-type opcodes with their ALU codes.
  logic [5:0] fn_code [10] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23, 6'h2A, 6'h00, 6'h02, 6'h03};
  logic [3:0] fn_alu  [10] = '{4'd2, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
  logic [5:0] it_op   [6]  = '{6'h0D, 6'h0C, 6'h0E, 6'h09, 6'h0F, 6'h23};
  logic [3:0] it_alu  [6]  = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd11, 4'd12};

  typedef struct packed {
    logic [3:0]  aluop;
    logic        re1, re2;
    logic [31:0] k1, k2;
    logic [4:0]  wd;
    logic        wreg, bad;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluop;
    logic [31:0] reg1, reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pc;
    logic        bad;
  } idex_t;

  idex_t exp_r = '0;

  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d = '0;
    d.bad = 1'b1;
    if (i[31:26] == 6'h00) begin
      for (int j = 0; j < 10; j++)
        if (i[5:0] == fn_code[j]) begin
          d.aluop = fn_alu[j]; d.wreg = 1'b1; d.wd = i[15:11]; d.bad = 1'b0;
          d.re2 = 1'b1;
          d.re1 = (fn_alu[j] < 4'd8);
          d.k1 = {27'b0, i[10:6]};
        end
    end else begin
      for (int j = 0; j < 6; j++)
        if (i[31:26] == it_op[j]) begin
          d.aluop = it_alu[j]; d.wreg = 1'b1; d.wd = i[20:16]; d.bad = 1'b0;
          d.re1 = (it_alu[j] != 4'd11);
          if (it_alu[j] == 4'd11)                           d.k2 = {i[15:0], 16'h0};
          else if (it_alu[j] == 4'd5 || it_alu[j] == 4'd12) d.k2 = 32'($signed(i[15:0]));
          else                                              d.k2 = {16'h0, i[15:0]};
        end
    end
    return d;
  endfunction

  function automatic logic [31:0] ref_operand(input logic re, input logic [4:0] a,
                                              input logic [31:0] k, input logic [31:0] rf);
    if (!re) return k;
    if (a == 5'd0) return 32'd0;
`ifdef ID_FORWARD_EN
    if (ex_we && ex_waddr == a) return ex_wdata;
    if (mem_we && mem_waddr == a) return mem_wdata;
`endif
    return rf;
  endfunction

  function automatic logic ref_hazard(input logic [4:0] a);
`ifdef ID_FORWARD_EN
    return ex_is_load && ex_we && ex_waddr != 5'd0 && ex_waddr == a;
`else
    return (ex_we && ex_waddr != 5'd0 && ex_waddr == a) ||
           (mem_we && mem_waddr != 5'd0 && mem_waddr == a);
`endif
  endfunction

  task automatic tick();
    dec_t        d;
    idex_t       nx;
    logic [4:0]  rs, rt;
    logic        st;
    #1;
    rs = id_inst[25:21];
    rt = id_inst[20:16];
    d  = ref_decode(id_inst);
    if (!id_valid) begin d.re1 = 1'b0; d.re2 = 1'b0; end
    st = id_valid && ((d.re1 && ref_hazard(rs)) || (d.re2 && ref_hazard(rt)));
    check("re1", re1, d.re1);
    check("re2", re2, d.re2);
    check("raddr1", raddr1, rs);
    check("raddr2", raddr2, rt);
    check("stall_req", stall_req, st);
    if (rst || flush)          nx = '0;
    else if (stall_in)         nx = exp_r;
    else if (st || !id_valid)  nx = '0;
    else begin
      nx.valid = 1'b1;
      nx.aluop = d.aluop;
      nx.reg1  = ref_operand(d.re1, rs, d.k1, rdata1);
      nx.reg2  = ref_operand(d.re2, rt, d.k2, rdata2);
      nx.wd    = d.wd;
      nx.wreg  = d.wreg;
      nx.pc    = id_pc;
      nx.bad   = d.bad;
    end
    @(posedge clk);
    exp_r = nx;
    #1;
    check("valid", ex_valid_o, exp_r.valid);
    check("aluop", ex_aluop_o, exp_r.aluop);
    check("reg1", ex_reg1_o, exp_r.reg1);
    check("reg2", ex_reg2_o, exp_r.reg2);
    check("wd", ex_wd_o, exp_r.wd);
    check("wreg", ex_wreg_o, exp_r.wreg);
    check("pc", ex_pc_o, exp_r.pc);
    check("inst_invalid", inst_invalid, exp_r.bad);
  endtask

  task automatic quiet();
    rst = 1'b0; flush = 1'b0; stall_in = 1'b0;
    ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0;
    mem_we = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'd0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i = $urandom;
    int k = $urandom_range(0, 15);
    i[25:21] = 5'($urandom_range(0, 7));
    i[20:16] = 5'($urandom_range(0, 7));
    if (k < 8) begin
      i[31:26] = 6'h00;
      i[15:11] = 5'($urandom_range(0, 7));
      if (k != 7) i[5:0] = fn_code[$urandom_range(0, 9)];
    end else if (k < 14) begin
      i[31:26] = it_op[k-8];
    end else begin
      i[31:26] = 6'($urandom);
    end
    return i;
  endfunction

  localparam logic [31:0] ORI1 = {6'h0D, 5'd0, 5'd1, 16'h1234};
  localparam logic [31:0] LUI2 = {6'h0F, 5'd0, 5'd2, 16'hABCD};
  localparam logic [31:0] ADDU = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] OR5  = {6'h00, 5'd4, 5'd6, 5'd5, 5'd0, 6'h25};

  initial begin
    quiet();
    rst = 1'b1; id_valid = 1'b1; id_pc = 32'h100; id_inst = ORI1;
    rdata1 = 32'h1111_1111; rdata2 = 32'h2222_2222;
    tick(); tick();
    check("rst_valid", ex_valid_o, 1'b0);
    check("rst_aluop", ex_aluop_o, 4'd0);
    rst = 1'b0;
    tick();
    check("ori_aluop", ex_aluop_o, 4'd1);
    check("ori_reg1", ex_reg1_o, 32'd0);
    check("ori_reg2", ex_reg2_o, 32'h0000_1234);
    check("ori_wd", ex_wd_o, 5'd1);
    id_inst = LUI2; id_pc = 32'h104;
    tick();
    check("lui_reg2", ex_reg2_o, 32'hABCD_0000);

    id_inst = ADDU; id_pc = 32'h108;
    ex_we = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'd5;
    mem_we = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'd7;
    tick();
`ifdef ID_FORWARD_EN
    check("fwd_reg1", ex_reg1_o, 32'd5);
    check("fwd_reg2", ex_reg2_o, 32'd7);
    mem_waddr = 5'd1;
    tick();
    check("fwd_ex_over_mem", ex_reg1_o, 32'd5);
`else
    check("nofwd_stall", stall_req, 1'b1);
    check("nofwd_bubble", ex_valid_o, 1'b0);
`endif

    quiet(); id_inst = OR5; id_pc = 32'h10C;
    ex_is_load = 1'b1; ex_we = 1'b1; ex_waddr = 5'd4;
    tick();
    check("lu_stall", stall_req, 1'b1);
    check("lu_bubble", ex_valid_o, 1'b0);
    ex_waddr = 5'd0;
    tick();
    check("lu_zero_nostall", stall_req, 1'b0);
    check("lu_zero_issue", ex_valid_o, 1'b1);

    quiet(); stall_in = 1'b1; id_inst = LUI2;
    tick(); tick(); tick();
    check("hold_aluop", ex_aluop_o, 4'd1);
    check("hold_pc", ex_pc_o, 32'h10C);
    flush = 1'b1;
    tick();
    check("flush_stall_bubble", ex_valid_o, 1'b0);

    quiet(); id_inst = OR5; mem_we = 1'b1; mem_waddr = 5'd6;
    tick();
`ifdef ID_FORWARD_EN
    check("mem_nostall", stall_req, 1'b0);
`else
    check("mem_stall", stall_req, 1'b1);
`endif
    quiet(); id_inst = {6'h3F, 26'h0};
    tick();
    check("bad_invalid", inst_invalid, 1'b1);
    check("bad_wreg", ex_wreg_o, 1'b0);

    for (int n = 0; n < 500; n++) begin
      rst        = ($urandom_range(0, 39) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      stall_in   = ($urandom_range(0, 5) == 0);
      id_valid   = ($urandom_range(0, 7) != 0);
      id_pc      = $urandom;
      id_inst    = rand_inst();
      rdata1     = $urandom;
      rdata2     = $urandom;
      ex_we      = $urandom_range(0, 1);
      ex_is_load = $urandom_range(0, 1);
      ex_waddr   = 5'($urandom_range(0, 7));
      ex_wdata   = $urandom;
      mem_we     = $urandom_range(0, 1);
      mem_waddr  = 5'($urandom_range(0, 7));
      mem_wdata  = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
